// File: rtl/seq_3lanpc_leg_pkg.sv
// Shared types for the 3-level ANPC leg sequencer: level codes, commutation
// types, sequencer states and the default timing width.
package seq_3lanpc_leg_pkg;

    localparam int TDELAY_WIDTH = 8;

    typedef enum logic [1:0] {
        type_I   = 2'd0,
        type_II  = 2'd1,
        type_III = 2'd2,
        type_IV  = 2'd3
    } _commtypes_t;

    typedef enum logic [1:0] {
        LEV_O   = 2'b00,
        LEV_P   = 2'b01,
        LEV_N   = 2'b10,
        LEV_INV = 2'b11
    } _vlev_t;

    typedef enum logic [2:0] {
        IDLE,
        HOLD,
        STABLE,
        VIA_ZERO,
        STOP_ZERO,
        FAULT_ZERO,
        LOCKOUT
    } _seqstate_t;

    // A direct jump between the two outer rails is not allowed; it must pass O.
    function automatic logic is_rail_swap(input logic [1:0] from_lev, input logic [1:0] to_lev);
        return ((from_lev == LEV_P) && (to_lev == LEV_N)) ||
               ((from_lev == LEV_N) && (to_lev == LEV_P));
    endfunction

endpackage

// File: rtl/seq_3lanpc_leg_if.sv
// Level-request channel from the modulator into the leg sequencer.
interface seq_3lanpc_leg_if;

    logic [1:0] lev_req;
    logic       lev_req_valid;
    logic       lev_req_ready;

    modport master (
        output lev_req,
        output lev_req_valid,
        input  lev_req_ready
    );

    modport slave (
        input  lev_req,
        input  lev_req_valid,
        output lev_req_ready
    );

endinterface

// File: rtl/seq_3lanpc_leg_timer.sv
// Down-counting hold timer: loads a value, counts to zero and parks there.
module hold_timer_3lanpc #(
    parameter int TDW = 8
) (
    input  logic           clk,
    input  logic           rst,
    input  logic           load,
    input  logic [TDW-1:0] load_val,
    output logic           expired,
    output logic [TDW-1:0] count
);

    localparam logic [TDW-1:0] ONE = {{(TDW-1){1'b0}}, 1'b1};

    logic [TDW-1:0] count_reg;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            count_reg <= '0;
        end else if (load) begin
            count_reg <= load_val;
        end else if (count_reg != '0) begin
            count_reg <= count_reg - ONE;
        end
    end

    assign count   = count_reg;
    assign expired = (count_reg == '0);

endmodule

// File: rtl/seq_3lanpc_leg.sv
// Per-leg commutation sequencer: enforces hold times, the O-level detour on
// rail swaps, stable-only comm_type updates and an ordered stop/fault shutdown.
module seq_3lanpc_leg
    import seq_3lanpc_leg_pkg::*;
#(
    parameter int TDW = TDELAY_WIDTH
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  en,
    input  logic                  fault,
    seq_3lanpc_leg_if.slave       req_if,
    input  _commtypes_t           comm_type_cfg,
    input  logic [TDW-1:0]        t_settle,
    input  logic [TDW-1:0]        t_dwell,
    output logic [1:0]            v_lev,
    output _commtypes_t           comm_type,
    output logic                  gate_en,
    output logic                  busy,
    output logic                  fault_latched,
    output logic                  err_invalid
);

    _seqstate_t     state_reg;
    logic [1:0]     v_lev_reg;
    logic [1:0]     target_reg;
    _commtypes_t    comm_type_reg;
    logic           gate_en_reg;
    logic           ready_reg;
    logic           busy_reg;
    logic           fault_latched_reg;
    logic           err_invalid_reg;

    logic [TDW-1:0] hold_max;
    logic [TDW-1:0] load_val;
    logic           load;
    logic           expired;
    logic [TDW-1:0] count;

    logic           active;
    logic           fault_hit;
    logic           stop_hit;
    logic           xfer;
    logic           req_moves;

    assign hold_max  = (t_settle > t_dwell) ? t_settle : t_dwell;
    assign active    = (state_reg == HOLD) || (state_reg == STABLE) || (state_reg == VIA_ZERO);
    assign fault_hit = active && fault;
    assign stop_hit  = active && !fault && !en;
    // A handshake is only acted on when no shutdown wins the same cycle.
    assign xfer      = (state_reg == STABLE) && !fault && en &&
                       req_if.lev_req_valid && ready_reg;
    assign req_moves = xfer && (req_if.lev_req != v_lev_reg) && (req_if.lev_req != LEV_INV);

    always_comb begin
        load     = 1'b0;
        load_val = hold_max;
        if (fault_hit || stop_hit) begin
            load     = 1'b1;
            load_val = t_settle;
        end else begin
            case (state_reg)
                IDLE:     load = en && !fault;
                STABLE:   load = req_moves;
                VIA_ZERO: load = expired;
                default:  load = 1'b0;
            endcase
        end
    end

    hold_timer_3lanpc #(.TDW(TDW)) u_timer (
        .clk      (clk),
        .rst      (rst),
        .load     (load),
        .load_val (load_val),
        .expired  (expired),
        .count    (count)
    );

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_reg         <= IDLE;
            v_lev_reg         <= LEV_O;
            target_reg        <= LEV_O;
            comm_type_reg     <= type_I;
            gate_en_reg       <= 1'b0;
            ready_reg         <= 1'b0;
            busy_reg          <= 1'b0;
            fault_latched_reg <= 1'b0;
            err_invalid_reg   <= 1'b0;
        end else begin
            if (state_reg == STABLE) begin
                comm_type_reg <= comm_type_cfg;
            end
            case (state_reg)
                IDLE: begin
                    if (fault) begin
                        fault_latched_reg <= 1'b1;
                        state_reg         <= LOCKOUT;
                    end else if (en) begin
                        gate_en_reg <= 1'b1;
                        busy_reg    <= 1'b1;
                        state_reg   <= HOLD;
                    end
                end
                HOLD, STABLE, VIA_ZERO: begin
                    if (fault_hit) begin
                        v_lev_reg <= LEV_O;
                        ready_reg <= 1'b0;
                        busy_reg  <= 1'b1;
                        state_reg <= FAULT_ZERO;
                    end else if (stop_hit) begin
                        v_lev_reg <= LEV_O;
                        ready_reg <= 1'b0;
                        busy_reg  <= 1'b1;
                        state_reg <= STOP_ZERO;
                    end else if (state_reg == HOLD) begin
                        if (expired) begin
                            ready_reg <= 1'b1;
                            busy_reg  <= 1'b0;
                            state_reg <= STABLE;
                        end
                    end else if (state_reg == VIA_ZERO) begin
                        if (expired) begin
                            v_lev_reg <= target_reg;
                            state_reg <= HOLD;
                        end
                    end else if (xfer) begin
                        if (req_if.lev_req == LEV_INV) begin
                            err_invalid_reg <= 1'b1;
                        end else if (req_moves) begin
                            ready_reg <= 1'b0;
                            busy_reg  <= 1'b1;
                            if (is_rail_swap(v_lev_reg, req_if.lev_req)) begin
                                v_lev_reg  <= LEV_O;
                                target_reg <= req_if.lev_req;
                                state_reg  <= VIA_ZERO;
                            end else begin
                                v_lev_reg <= req_if.lev_req;
                                state_reg <= HOLD;
                            end
                        end
                    end
                end
                STOP_ZERO: begin
                    // A fault during a stop keeps the running settle count.
                    if (fault) begin
                        state_reg <= FAULT_ZERO;
                    end else if (expired) begin
                        gate_en_reg     <= 1'b0;
                        busy_reg        <= 1'b0;
                        err_invalid_reg <= 1'b0;
                        state_reg       <= IDLE;
                    end
                end
                FAULT_ZERO: begin
                    if (expired) begin
                        gate_en_reg       <= 1'b0;
                        busy_reg          <= 1'b0;
                        fault_latched_reg <= 1'b1;
                        state_reg         <= LOCKOUT;
                    end
                end
                LOCKOUT: begin
                    if (!en && !fault) begin
                        fault_latched_reg <= 1'b0;
                        err_invalid_reg   <= 1'b0;
                        state_reg         <= IDLE;
                    end
                end
                default: state_reg <= IDLE;
            endcase
        end
    end

    assign req_if.lev_req_ready = ready_reg;
    assign v_lev                = v_lev_reg;
    assign comm_type            = comm_type_reg;
    assign gate_en              = gate_en_reg;
    assign busy                 = busy_reg;
    assign fault_latched        = fault_latched_reg;
    assign err_invalid          = err_invalid_reg;

endmodule

// File: tb/tb_seq_3lanpc_leg.sv
// Scoreboard bench for seq_3lanpc_leg: the driver predicts timed output
// change events, a negedge monitor pops and compares each observed change.
module tb_seq_3lanpc_leg;
    import seq_3lanpc_leg_pkg::*;

    localparam int TDW = TDELAY_WIDTH;
    localparam int K_LEV = 0, K_COMM = 1, K_RDY = 2, K_BUSY = 3, K_ERR = 4, K_GATE = 5, K_FLT = 6;

    typedef struct {
        int cyc;
        int kind;
        int val;
    } ev_t;

    logic           clk = 1'b0;
    logic           rst = 1'b1;
    logic           en = 1'b0;
    logic           fault = 1'b0;
    _commtypes_t    cfg = type_I;
    logic [TDW-1:0] t_settle = '0;
    logic [TDW-1:0] t_dwell = '0;
    logic [1:0]     v_lev;
    _commtypes_t    comm_type;
    logic           gate_en, busy, fault_latched, err_invalid;

    seq_3lanpc_leg_if bus ();

    seq_3lanpc_leg #(.TDW(TDW)) dut (
        .clk           (clk),
        .rst           (rst),
        .en            (en),
        .fault         (fault),
        .req_if        (bus),
        .comm_type_cfg (cfg),
        .t_settle      (t_settle),
        .t_dwell       (t_dwell),
        .v_lev         (v_lev),
        .comm_type     (comm_type),
        .gate_en       (gate_en),
        .busy          (busy),
        .fault_latched (fault_latched),
        .err_invalid   (err_invalid)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    ev_t sb[$];
    int  vectors = 0;
    int  miscompares = 0;
    bit  tmo_req = 0, tmo_seen = 0, end_req = 0, end_done = 0, rst_done = 0;

    // Reference model of the leg as seen from outside.
    int m_lev = 0, m_comm = 0;
    bit m_err = 0;

    function automatic string kname(input int k);
        case (k)
            K_LEV:   return "v_lev";
            K_COMM:  return "comm_type";
            K_RDY:   return "ready";
            K_BUSY:  return "busy";
            K_ERR:   return "err_invalid";
            K_GATE:  return "gate_en";
            default: return "fault_latched";
        endcase
    endfunction

    function automatic int imax(input int a, input int b);
        return (a > b) ? a : b;
    endfunction

    task automatic push(input int c, input int k, input int v);
        ev_t e;
        e.cyc = c; e.kind = k; e.val = v;
        sb.push_back(e);
    endtask

    // ---------------- monitor / checker ----------------
    task automatic chk_rst(input string name, input int act, input int exp);
        vectors++;
        if (act != exp) begin
            miscompares++;
            $display("FAIL reset_%s: got %0d, expected %0d", name, act, exp);
        end
    endtask

    task automatic observe(input int k, input int v);
        ev_t e;
        vectors++;
        if (sb.size() == 0) begin
            miscompares++;
            $display("FAIL unexpected_%s: changed to %0d at cycle %0d, no change expected", kname(k), v, cyc);
        end else begin
            e = sb.pop_front();
            if (e.kind != k || e.cyc != cyc || e.val != v) begin
                miscompares++;
                $display("FAIL event: got %s=%0d at cycle %0d, expected %s=%0d at cycle %0d",
                         kname(k), v, cyc, kname(e.kind), e.val, e.cyc);
            end
        end
    endtask

    logic [1:0]  p_lev = 2'b00;
    _commtypes_t p_comm = type_I;
    logic        p_rdy = 1'b0, p_busy = 1'b0, p_err = 1'b0, p_gate = 1'b0, p_flt = 1'b0;

    always @(negedge clk) begin
        if (!rst) begin
            if (!rst_done) begin
                chk_rst("v_lev", int'(v_lev), 0);
                chk_rst("comm_type", int'(comm_type), int'(type_I));
                chk_rst("gate_en", int'(gate_en), 0);
                chk_rst("ready", int'(bus.lev_req_ready), 0);
                chk_rst("busy", int'(busy), 0);
                chk_rst("fault_latched", int'(fault_latched), 0);
                chk_rst("err_invalid", int'(err_invalid), 0);
                rst_done = 1;
            end
        end else begin
            if (v_lev !== p_lev)                    observe(K_LEV, int'(v_lev));
            if (comm_type !== p_comm)               observe(K_COMM, int'(comm_type));
            if (bus.lev_req_ready !== p_rdy)        observe(K_RDY, int'(bus.lev_req_ready));
            if (busy !== p_busy)                    observe(K_BUSY, int'(busy));
            if (err_invalid !== p_err)              observe(K_ERR, int'(err_invalid));
            if (gate_en !== p_gate)                 observe(K_GATE, int'(gate_en));
            if (fault_latched !== p_flt)            observe(K_FLT, int'(fault_latched));
        end
        p_lev = v_lev; p_comm = comm_type; p_rdy = bus.lev_req_ready; p_busy = busy;
        p_err = err_invalid; p_gate = gate_en; p_flt = fault_latched;
        if (tmo_req && !tmo_seen) begin
            vectors++;
            miscompares++;
            $display("FAIL ready_timeout: ready still 0 after 1000 cycles, expected 1");
            tmo_seen = 1;
        end
        if (end_req && !end_done) begin
            vectors++;
            if (sb.size() != 0) begin
                miscompares++;
                $display("FAIL missing_events: %0d pending, first %s=%0d due at cycle %0d",
                         sb.size(), kname(sb[0].kind), sb[0].val, sb[0].cyc);
            end
            end_done = 1;
        end
    end

    // ---------------- driver ----------------
    task automatic abort_run();
        tmo_req = 1;
        repeat (2) @(negedge clk);
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    endtask

    task automatic wait_ready();
        int n = 0;
        while (bus.lev_req_ready !== 1'b1) begin
            @(negedge clk);
            n++;
            if (n > 1000) abort_run();
        end
    endtask

    task automatic start_leg(input int ts, input int td);
        int c, h;
        t_settle = ts[TDW-1:0];
        t_dwell  = td[TDW-1:0];
        en = 1'b1;
        c = cyc + 1;
        h = imax(ts, td);
        push(c, K_BUSY, 1);
        push(c, K_GATE, 1);
        push(c + h + 1, K_RDY, 1);
        push(c + h + 1, K_BUSY, 0);
        wait_ready();
    endtask

    task automatic request(input logic [1:0] req, input _commtypes_t c_new, input bit early,
                           input int ts, input int td);
        int e, h, r;
        if (!early) begin
            wait_ready();
            t_settle = ts[TDW-1:0];
            t_dwell  = td[TDW-1:0];
        end
        bus.lev_req = req;
        bus.lev_req_valid = 1'b1;
        cfg = c_new;
        wait_ready();
        e = cyc + 1;
        h = imax(int'(t_settle), int'(t_dwell));
        r = int'(req);
        if (r == 3) begin
            if (int'(c_new) != m_comm) push(e, K_COMM, int'(c_new));
            if (!m_err) push(e, K_ERR, 1);
            m_err = 1;
        end else if (r == m_lev) begin
            if (int'(c_new) != m_comm) push(e, K_COMM, int'(c_new));
        end else if (m_lev != 0 && r != 0) begin
            push(e, K_LEV, 0);
            if (int'(c_new) != m_comm) push(e, K_COMM, int'(c_new));
            push(e, K_RDY, 0);
            push(e, K_BUSY, 1);
            push(e + h + 1, K_LEV, r);
            push(e + 2 * h + 2, K_RDY, 1);
            push(e + 2 * h + 2, K_BUSY, 0);
            m_lev = r;
        end else begin
            push(e, K_LEV, r);
            if (int'(c_new) != m_comm) push(e, K_COMM, int'(c_new));
            push(e, K_RDY, 0);
            push(e, K_BUSY, 1);
            push(e + h + 1, K_RDY, 1);
            push(e + h + 1, K_BUSY, 0);
            m_lev = r;
        end
        m_comm = int'(c_new);
        $display("req lev=%0d comm=%0d H=%0d accepted at cycle %0d", r, int'(c_new), h, e);
        @(negedge clk);
        bus.lev_req_valid = 1'b0;
    endtask

    task automatic stop_leg(input int ts);
        int c;
        wait_ready();
        t_settle = ts[TDW-1:0];
        en = 1'b0;
        c = cyc + 1;
        if (m_lev != 0) push(c, K_LEV, 0);
        push(c, K_RDY, 0);
        push(c, K_BUSY, 1);
        push(c + ts + 1, K_BUSY, 0);
        if (m_err) push(c + ts + 1, K_ERR, 0);
        push(c + ts + 1, K_GATE, 0);
        m_lev = 0;
        m_err = 0;
        $display("stop at cycle %0d settle=%0d", c, ts);
        while (cyc < c + ts + 2) @(negedge clk);
    endtask

    task automatic fault_leg(input int ts, input int linger);
        int c;
        wait_ready();
        t_settle = ts[TDW-1:0];
        fault = 1'b1;
        c = cyc + 1;
        if (m_lev != 0) push(c, K_LEV, 0);
        push(c, K_RDY, 0);
        push(c, K_BUSY, 1);
        push(c + ts + 1, K_BUSY, 0);
        push(c + ts + 1, K_GATE, 0);
        push(c + ts + 1, K_FLT, 1);
        m_lev = 0;
        $display("fault at cycle %0d settle=%0d", c, ts);
        @(negedge clk);
        fault = 1'b0;
        while (cyc < c + ts + 1 + linger) @(negedge clk);
        en = 1'b0;
        c = cyc + 1;
        if (m_err) push(c, K_ERR, 0);
        push(c, K_FLT, 0);
        m_err = 0;
        repeat (2) @(negedge clk);
    endtask

    initial begin
        int sel;
        bus.lev_req = 2'b00;
        bus.lev_req_valid = 1'b0;
        #1 rst = 1'b0;
        repeat (3) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);

        start_leg(7, 3);
        request(2'b01, type_I, 1'b0, 10, 4);
        request(2'b10, type_I, 1'b1, 10, 4);
        request(2'b01, type_II, 1'b1, 10, 4);
        fault_leg(6, 5);
        start_leg(2, 0);
        request(2'b10, type_I, 1'b0, 3, 1);
        request(2'b11, type_I, 1'b0, 3, 1);
        request(2'b10, type_III, 1'b0, 0, 0);
        stop_leg(5);
        start_leg(0, 0);

        for (int i = 0; i < 150; i++) begin
            sel = $urandom_range(0, 19);
            if (sel == 0) begin
                fault_leg($urandom_range(0, 9), $urandom_range(1, 6));
                start_leg($urandom_range(0, 9), $urandom_range(0, 9));
            end else if (sel == 1) begin
                stop_leg($urandom_range(0, 9));
                start_leg($urandom_range(0, 9), $urandom_range(0, 9));
            end else begin
                request(2'($urandom_range(0, 3)), _commtypes_t'($urandom_range(0, 3)),
                        1'($urandom_range(0, 1)), $urandom_range(0, 12), $urandom_range(0, 12));
            end
        end
        stop_leg(3);

        end_req = 1;
        for (int n = 0; n < 10 && !end_done; n++) @(negedge clk);
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/seq_3lanpc_leg.md
Name: seq_3lanpc_leg

Overview:
Per-leg commutation sequencer placed in front of fsm_3lanpc. It accepts requested output levels from the modulator over a valid/ready handshake and drives v_lev and comm_type into the FSM. It enforces these rules:
- a hold (settle/min-dwell) time after every level change;
- a forced pass through the O level on P<->N requests;
- comm_type changes only while the leg is stable;
- an ordered stop/fault shutdown: O level, then settle, then gate disable.

Parameters:
TDW, `TDELAY_WIDTH, width of all timing inputs and the hold counter.

Ports:
clk  in  1  system clock
rst  in  1  asynchronous, active-low reset (0 = reset)
en  in  1  leg enable; level-sensitive
fault  in  1  synchronous fault request; highest priority
lev_req  in  2  requested level: 00=O, 01=P, 10=N, 11=invalid
lev_req_valid  in  1  request valid
lev_req_ready  out  1  request accepted when valid&&ready
comm_type_cfg  in  _commtypes_t  desired commutation type
t_settle  in  TDW  FSM transition settle time, in cycles
t_dwell  in  TDW  minimum level dwell, in cycles
v_lev  out  2  level to fsm_3lanpc
comm_type  out  _commtypes_t  commutation type to fsm_3lanpc
gate_en  out  1  gate driver enable
busy  out  1  1 in any state other than IDLE, STABLE or LOCKOUT
fault_latched  out  1  sticky fault flag
err_invalid  out  1  sticky flag: a request of 11 was accepted

Behaviour:
- Reset (rst=0, async): state=IDLE, v_lev=00, comm_type=type_I, gate_en=0, lev_req_ready=0, busy=0, fault_latched=0, err_invalid=0, counter=0. All outputs are registered.
- H = max(t_settle, t_dwell). H is sampled at every counter load; later changes to timing inputs have no effect on a running hold.
- Counter timing: loaded on the edge where v_lev changes, decrements every cycle, and the state exits on the edge where counter==0 is observed. The level is held H+1 cycles (H=0 gives 1 cycle).
- lev_req_ready = 1 only in STABLE.
- comm_type <= comm_type_cfg every cycle in STABLE, including the handshake cycle, so a new type and a new level appear on the same edge. comm_type is frozen in all other states.
- States and transitions:
  - IDLE: v_lev=00, gate_en=0.
    - en=1 && fault=0: gate_en<=1, load H, go to HOLD.
    - fault=1: fault_latched<=1, go to LOCKOUT.
  - HOLD: wait for counter==0, then go to STABLE.
  - STABLE, on transfer:
    - req == v_lev: no change, no hold, stay in STABLE.
    - req 11: err_invalid<=1, v_lev unchanged, stay in STABLE.
    - O<->P or O<->N: v_lev<=req next edge, load H, go to HOLD.
    - P<->N: v_lev<=00, store target, load H, go to VIA_ZERO.
  - VIA_ZERO: on counter==0, v_lev<=target, load H, go to HOLD.
  - Any active state (HOLD, STABLE, VIA_ZERO):
    - fault=1: v_lev<=00, load t_settle, go to FAULT_ZERO.
    - else en=0: v_lev<=00, load t_settle, go to STOP_ZERO. A transfer in the same cycle is dropped.
  - STOP_ZERO:
    - on counter==0: gate_en<=0, go to IDLE.
    - fault=1: upgrade to FAULT_ZERO, keeping the counter.
  - FAULT_ZERO: on counter==0, gate_en<=0, fault_latched<=1, go to LOCKOUT.
    - fault is not re-checked; the sequence completes even if fault drops.
  - LOCKOUT: v_lev=00, gate_en=0. Leave to IDLE only when en=0 && fault=0. This also clears fault_latched and err_invalid.
- Simultaneous events: fault > en=0 > handshake.
- A transition to zero is always followed by a wait, even when v_lev is already 00.
- err_invalid is also cleared on leaving STOP_ZERO to IDLE.

Decomposition:
- PKG_decoder_3lxnpc gains:
  - _vlev_t enum: LEV_O=2'b00, LEV_P=2'b01, LEV_N=2'b10, LEV_INV=2'b11;
  - _seqstate_t enum: IDLE, HOLD, STABLE, VIA_ZERO, STOP_ZERO, FAULT_ZERO, LOCKOUT.
- _commtypes_t and `TDELAY_WIDTH are reused from the package.
- One sub-module: hold_timer_3lanpc.
  - Inputs: load, load value (TDW bits).
  - Outputs: expired (counter==0), and the counter itself.
- The max() selection stays in the sequencer.

Test Plan:
- Reset/start: rst=0 then rst=1, en=1, t_settle=7, t_dwell=3 -> gate_en=1 at edge 1 after en; ready=1 at edge 9; v_lev=00 throughout; comm_type=type_I.
- O->P: t_settle=10, t_dwell=4, req 01 -> v_lev=01 next edge; ready low exactly 11 cycles; a second request held valid is accepted on cycle 12.
- P->N: req 10 from P with H=10 -> v_lev=00 for 11 cycles, then 10 for 11 cycles, busy=1 throughout; ready returns 22 cycles after the handshake.
- comm_type freeze: comm_type_cfg changes type_I->type_II during HOLD -> comm_type stays type_I until STABLE, then becomes type_II. With a request issued on that STABLE cycle, v_lev and comm_type change on the same edge.
- Fault: at v_lev=01 with t_settle=6, fault pulse of 1 cycle -> v_lev=00 next edge; gate_en=0 and fault_latched=1 after 7 cycles. ready stays 0 while en=1; after en=0 the block enters IDLE, and fault_latched and err_invalid clear.
- Invalid and stop:
  - req 11 -> err_invalid=1, v_lev unchanged, ready stays 1.
  - en=0 at v_lev=10 with t_settle=5 -> v_lev=00 next edge, gate_en=0 after 6 cycles, fault_latched=0.
